// File: rtl/exe_md.sv
// exe_md: integer execute unit. Single-cycle ALU ops are registered in one
// cycle; MUL/MULH/MULHU run on a radix-2 shift-add engine for XLEN cycles.
// Define EXE_MD_DIV_EN to add a restoring divider (DIV/DIVU/REM/REMU) that
// shares the iterative engine; without it those opcodes are unknown ops.
module exe_md #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int AOP_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [XLEN-1:0]    op1_i,
   input  logic [XLEN-1:0]    op2_i,
   input  logic [AOP_W-1:0]   aluOp_i,
   input  logic               reg_we_i,
   input  logic [RADDR_W-1:0] reg_waddr_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               valid_o,
   output logic               reg_we_o,
   output logic [RADDR_W-1:0] reg_waddr_o,
   output logic [XLEN-1:0]    reg_wdata_o
);
   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN + 1);

   localparam logic [AOP_W-1:0] OP_ADD   = AOP_W'(1);
   localparam logic [AOP_W-1:0] OP_SUB   = AOP_W'(2);
   localparam logic [AOP_W-1:0] OP_AND   = AOP_W'(3);
   localparam logic [AOP_W-1:0] OP_OR    = AOP_W'(4);
   localparam logic [AOP_W-1:0] OP_XOR   = AOP_W'(5);
   localparam logic [AOP_W-1:0] OP_SLT   = AOP_W'(6);
   localparam logic [AOP_W-1:0] OP_SLTU  = AOP_W'(7);
   localparam logic [AOP_W-1:0] OP_SLL   = AOP_W'(8);
   localparam logic [AOP_W-1:0] OP_SRL   = AOP_W'(9);
   localparam logic [AOP_W-1:0] OP_SRA   = AOP_W'(10);
   localparam logic [AOP_W-1:0] OP_MUL   = AOP_W'(16);
   localparam logic [AOP_W-1:0] OP_MULH  = AOP_W'(17);
   localparam logic [AOP_W-1:0] OP_MULHU = AOP_W'(18);
`ifdef EXE_MD_DIV_EN
   localparam logic [AOP_W-1:0] OP_DIV   = AOP_W'(19);
   localparam logic [AOP_W-1:0] OP_REM   = AOP_W'(21);
   localparam logic [AOP_W-1:0] OP_REMU  = AOP_W'(22);
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 valid_q, we_q;
   logic [RADDR_W-1:0]   waddr_q;
   logic [XLEN-1:0]      wdata_q;

   // iterative engine: {hi,lo} is product or {remainder,quotient}
   logic [XLEN-1:0]      hi_q, lo_q, mcand_q;
   logic [XLEN-1:0]      hi_d, lo_d;
   logic                 neg_q, we_lat_q;
   logic [RADDR_W-1:0]   waddr_lat_q;
   logic [AOP_W-1:0]     op_q;

   logic                 accept_multi;
   logic                 a_neg, b_neg, neg_init;
   logic [XLEN-1:0]      a_mag, b_mag, lo_init, mcand_init, res_done;
   logic [XLEN:0]        mul_sum;
   logic [2*XLEN-1:0]    prod_s;
`ifdef EXE_MD_DIV_EN
   logic [XLEN:0]        rsh;
`endif

   function automatic logic is_single(input logic [AOP_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_SRA);
   endfunction

`ifdef EXE_MD_DIV_EN
   function automatic logic is_div(input logic [AOP_W-1:0] op);
      return (op >= OP_DIV) && (op <= OP_REMU);
   endfunction

   function automatic logic is_rem(input logic [AOP_W-1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_multi(input logic [AOP_W-1:0] op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [AOP_W-1:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction
`else
   function automatic logic is_multi(input logic [AOP_W-1:0] op);
      return (op >= OP_MUL) && (op <= OP_MULHU);
   endfunction

   function automatic logic is_signed_op(input logic [AOP_W-1:0] op);
      return op == OP_MULH;
   endfunction
`endif

   function automatic logic [XLEN-1:0] alu(input logic [AOP_W-1:0] op,
                                           input logic [XLEN-1:0]  a,
                                           input logic [XLEN-1:0]  b);
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         OP_SLT:  alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu = {{(XLEN-1){1'b0}}, (a < b)};
         OP_SLL:  alu = a << sh;
         OP_SRL:  alu = a >> sh;
         OP_SRA:  alu = XLEN'($signed(a) >>> sh);
         default: alu = '0;
      endcase
   endfunction

   // accept decode and operand conditioning (signed ops run on magnitudes)
   always_comb begin
      accept_multi = (state_q == S_IDLE) && valid_i && !flush_i && !rst_i &&
                     is_multi(aluOp_i);
      stall_o      = (state_q == S_BUSY) || accept_multi;
      a_neg        = is_signed_op(aluOp_i) && op1_i[XLEN-1];
      b_neg        = is_signed_op(aluOp_i) && op2_i[XLEN-1];
      a_mag        = a_neg ? -op1_i : op1_i;
      b_mag        = b_neg ? -op2_i : op2_i;
      lo_init      = b_mag;
      mcand_init   = a_mag;
      neg_init     = a_neg ^ b_neg;
`ifdef EXE_MD_DIV_EN
      if (is_div(aluOp_i)) begin
         lo_init    = a_mag;
         mcand_init = b_mag;
         // divide by zero keeps the all-ones quotient unnegated
         neg_init   = is_rem(aluOp_i) ? a_neg : (a_neg ^ b_neg) && (op2_i != '0);
      end
`endif
   end

   // one engine step: shift-add multiply or restoring divide
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      hi_d    = mul_sum[XLEN:1];
      lo_d    = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef EXE_MD_DIV_EN
      rsh     = {hi_q, lo_q[XLEN-1]};
      if (is_div(op_q)) begin
         if (rsh >= {1'b0, mcand_q}) begin
            hi_d = XLEN'(rsh - {1'b0, mcand_q});
            lo_d = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_d = rsh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
         end
      end
`endif
   end

   // final sign fix-up and result selection
   always_comb begin
      prod_s   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      res_done = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef EXE_MD_DIV_EN
      if (is_div(op_q)) begin
         if (is_rem(op_q)) res_done = neg_q ? -hi_q : hi_q;
         else              res_done = neg_q ? -lo_q : lo_q;
      end
`endif
   end

   // engine datapath: load on accept, iterate while busy
   always_ff @(posedge clk_i) begin
      if (accept_multi) begin
         hi_q        <= '0;
         lo_q        <= lo_init;
         mcand_q     <= mcand_init;
         neg_q       <= neg_init;
         op_q        <= aluOp_i;
         we_lat_q    <= reg_we_i && (reg_waddr_i != '0);
         waddr_lat_q <= reg_waddr_i;
      end else if (state_q == S_BUSY) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // control FSM and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               valid_q <= 1'b0;
               if (valid_i) begin
                  if (is_multi(aluOp_i)) begin
                     state_q <= S_BUSY;
                     cnt_q   <= '0;
                  end else if (is_single(aluOp_i)) begin
                     valid_q <= 1'b1;
                     we_q    <= reg_we_i && (reg_waddr_i != '0);
                     waddr_q <= reg_waddr_i;
                     wdata_q <= alu(aluOp_i, op1_i, op2_i);
                  end else begin
                     valid_q <= 1'b1;
                     we_q    <= 1'b0;
                     waddr_q <= '0;
                     wdata_q <= '0;
                  end
               end
            end
            S_BUSY: begin
               valid_q <= 1'b0;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) state_q <= S_DONE;
            end
            S_DONE: begin
               valid_q <= 1'b1;
               we_q    <= we_lat_q;
               waddr_q <= waddr_lat_q;
               wdata_q <= res_done;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign valid_o     = valid_q;
   assign reg_we_o    = we_q;
   assign reg_waddr_o = waddr_q;
   assign reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_exe_md.sv
// tb_exe_md: vector table, directed corner sequences and randomized ops
// against an arithmetic reference model. Honours EXE_MD_DIV_EN.
module tb_exe_md;
   logic        clk = 1'b0;
   logic        rst_i, valid_i, reg_we_i, flush_i;
   logic [31:0] op1_i, op2_i;
   logic [7:0]  aluOp_i;
   logic [4:0]  reg_waddr_i;
   logic        stall_o, valid_o, reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exe_md dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .op1_i(op1_i), .op2_i(op2_i),
      .aluOp_i(aluOp_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
      .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o), .reg_we_o(reg_we_o),
      .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
   );

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a, b;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] ed;
      logic        ewe;
      logic [4:0]  ewa;
   } vec_t;

   vec_t       tbl[14];
   logic [7:0] ops[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // reference model: result from plain arithmetic, latency from op class
   function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic we, input logic [4:0] wa,
                                 output logic [31:0] ed, output logic ewe,
                                 output logic [4:0] ewa, output int lat);
      longint      sa, sb, t;
      logic [63:0] pu;
      logic        known;
      sa = $signed(a);
      sb = $signed(b);
      pu = {32'b0, a} * {32'b0, b};
      known = 1'b1;
      lat = 1;
      ed = '0;
      case (op)
         8'd1:  ed = a + b;
         8'd2:  ed = a - b;
         8'd3:  ed = a & b;
         8'd4:  ed = a | b;
         8'd5:  ed = a ^ b;
         8'd6:  ed = (sa < sb) ? 32'd1 : 32'd0;
         8'd7:  ed = (a < b) ? 32'd1 : 32'd0;
         8'd8:  ed = a << b[4:0];
         8'd9:  ed = a >> b[4:0];
         8'd10: ed = $signed(a) >>> b[4:0];
         8'd16: begin ed = pu[31:0]; lat = 34; end
         8'd17: begin t = sa * sb; ed = t[63:32]; lat = 34; end
         8'd18: begin ed = pu[63:32]; lat = 34; end
`ifdef EXE_MD_DIV_EN
         8'd19: begin
            lat = 34;
            if (b == 0) ed = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ed = a;
            else begin t = sa / sb; ed = t[31:0]; end
         end
         8'd20: begin lat = 34; ed = (b == 0) ? 32'hFFFFFFFF : a / b; end
         8'd21: begin
            lat = 34;
            if (b == 0) ed = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ed = 0;
            else begin t = sa % sb; ed = t[31:0]; end
         end
         8'd22: begin lat = 34; ed = (b == 0) ? a : a % b; end
`endif
         default: known = 1'b0;
      endcase
      if (known) begin
         ewe = we && (wa != 0);
         ewa = wa;
      end else begin
         ed  = '0;
         ewe = 1'b0;
         ewa = '0;
      end
   endfunction

   // present one op, hold it until valid_o, check latency, stall time and result
   task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] wa, output logic [31:0] got);
      logic [31:0] ed;
      logic        ewe;
      logic [4:0]  ewa;
      int          lat, cyc, nst;
      logic        done;
      model(op, a, b, we, wa, ed, ewe, ewa, lat);
      aluOp_i = op; op1_i = a; op2_i = b; reg_we_i = we; reg_waddr_i = wa;
      valid_i = 1'b1;
      cyc = 0; nst = 0; done = 1'b0;
      while (!done && cyc < 100) begin
         #1;
         if (stall_o) nst++;
         tick();
         cyc++;
         if (valid_o) done = 1'b1;
      end
      valid_i = 1'b0;
      chk($sformatf("op%0d_latency", op), cyc, lat);
      chk($sformatf("op%0d_stall_cycles", op), nst, (lat == 1) ? 0 : 33);
      chk($sformatf("op%0d_data a=%h b=%h", op, a, b), reg_wdata_o, ed);
      chk($sformatf("op%0d_we", op), reg_we_o, ewe);
      chk($sformatf("op%0d_waddr", op), reg_waddr_o, ewa);
      got = reg_wdata_o;
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, held;
      int          seen;

      tbl[0]  = '{8'd1,  32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd5,  32'h80000000, 1'b1, 5'd5};
      tbl[1]  = '{8'd10, 32'h80000000, 32'h00000024, 1'b1, 5'd6,  32'hF8000000, 1'b1, 5'd6};
      tbl[2]  = '{8'd2,  32'h00000000, 32'h00000001, 1'b1, 5'd7,  32'hFFFFFFFF, 1'b1, 5'd7};
      tbl[3]  = '{8'd6,  32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd8,  32'h00000001, 1'b1, 5'd8};
      tbl[4]  = '{8'd7,  32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd9,  32'h00000000, 1'b1, 5'd9};
      tbl[5]  = '{8'd8,  32'h00000001, 32'h0000003F, 1'b1, 5'd10, 32'h80000000, 1'b1, 5'd10};
      tbl[6]  = '{8'd9,  32'h80000000, 32'h00000004, 1'b1, 5'd11, 32'h08000000, 1'b1, 5'd11};
      tbl[7]  = '{8'd3,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd12, 32'hF000F000, 1'b1, 5'd12};
      tbl[8]  = '{8'd4,  32'hF0F0F0F0, 32'h0F0F0000, 1'b1, 5'd13, 32'hFFFFF0F0, 1'b1, 5'd13};
      tbl[9]  = '{8'd5,  32'hFFFF0000, 32'h0FF00FF0, 1'b1, 5'd14, 32'hF00F0FF0, 1'b1, 5'd14};
      tbl[10] = '{8'd1,  32'h00000002, 32'h00000003, 1'b1, 5'd0,  32'h00000005, 1'b0, 5'd0};
      tbl[11] = '{8'd1,  32'h00000002, 32'h00000003, 1'b0, 5'd4,  32'h00000005, 1'b0, 5'd4};
      tbl[12] = '{8'd11, 32'h00000005, 32'h00000006, 1'b1, 5'd3,  32'h00000000, 1'b0, 5'd0};
`ifdef EXE_MD_DIV_EN
      tbl[13] = '{8'd10, 32'h7FFFFFF0, 32'h00000004, 1'b1, 5'd15, 32'h07FFFFFF, 1'b1, 5'd15};
`else
      tbl[13] = '{8'd19, 32'h00000007, 32'h00000002, 1'b1, 5'd3,  32'h00000000, 1'b0, 5'd0};
`endif
      ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
              8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd0};

      rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; reg_we_i = 1'b0;
      op1_i = '0; op2_i = '0; aluOp_i = '0; reg_waddr_i = '0;
      repeat (2) tick();
      chk("rst_valid", valid_o, 0);
      chk("rst_we", reg_we_o, 0);
      chk("rst_waddr", reg_waddr_o, 0);
      chk("rst_wdata", reg_wdata_o, 0);
      chk("rst_stall", stall_o, 0);
      rst_i = 1'b0;
      tick();

      // single-cycle and unknown ops
      for (int i = 0; i < 14; i++) begin
         aluOp_i = tbl[i].op; op1_i = tbl[i].a; op2_i = tbl[i].b;
         reg_we_i = tbl[i].we; reg_waddr_i = tbl[i].wa; valid_i = 1'b1;
         #1;
         chk($sformatf("tbl%0d_stall", i), stall_o, 0);
         tick();
         valid_i = 1'b0;
         chk($sformatf("tbl%0d_valid", i), valid_o, 1);
         chk($sformatf("tbl%0d_data", i), reg_wdata_o, tbl[i].ed);
         chk($sformatf("tbl%0d_we", i), reg_we_o, tbl[i].ewe);
         chk($sformatf("tbl%0d_waddr", i), reg_waddr_o, tbl[i].ewa);
         tick();
         chk($sformatf("tbl%0d_idle_valid", i), valid_o, 0);
         chk($sformatf("tbl%0d_held_data", i), reg_wdata_o, tbl[i].ed);
      end

      // multiplier corner cases
      run_op(8'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd1, got);
      chk("mulhu_const", got, 32'hFFFFFFFE);
      tick();
      run_op(8'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd2, got);
      chk("mul_const", got, 32'h00000001);
      tick();
      run_op(8'd17, 32'h80000000, 32'h80000000, 1'b1, 5'd3, got);
      chk("mulh_const", got, 32'h40000000);
      tick();

`ifdef EXE_MD_DIV_EN
      run_op(8'd19, 32'h80000000, 32'hFFFFFFFF, 1'b1, 5'd4, got);
      chk("div_ovf_const", got, 32'h80000000);
      tick();
      run_op(8'd20, 32'd7, 32'd0, 1'b1, 5'd4, got);
      chk("divu_zero_const", got, 32'hFFFFFFFF);
      tick();
      run_op(8'd21, 32'd7, 32'd0, 1'b1, 5'd4, got);
      chk("rem_zero_const", got, 32'd7);
      tick();
      run_op(8'd21, 32'hFFFFFFF9, 32'd2, 1'b1, 5'd4, got);
      chk("rem_neg_const", got, 32'hFFFFFFFF);
      tick();
`else
      run_op(8'd19, 32'd7, 32'd2, 1'b1, 5'd4, got);
      chk("div_disabled_const", got, 32'h0);
      tick();
`endif

      // flush in the 10th BUSY cycle of a MUL
      aluOp_i = 8'd16; op1_i = 32'd3; op2_i = 32'd5; reg_we_i = 1'b1; reg_waddr_i = 5'd2;
      valid_i = 1'b1;
      #1;
      chk("flush_accept_stall", stall_o, 1);
      tick();
      repeat (9) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; valid_i = 1'b0;
      #1;
      chk("flush_stall", stall_o, 0);
      chk("flush_valid", valid_o, 0);
      aluOp_i = 8'd1; op1_i = 32'd2; op2_i = 32'd3; reg_waddr_i = 5'd5; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      chk("post_flush_valid", valid_o, 1);
      chk("post_flush_data", reg_wdata_o, 32'd5);
      seen = 0;
      repeat (40) begin
         tick();
         if (valid_o) seen++;
      end
      chk("flush_no_late_valid", seen, 0);

      // flush has priority over valid in IDLE
      aluOp_i = 8'd1; op1_i = 32'd4; op2_i = 32'd4; reg_waddr_i = 5'd6;
      valid_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("idle_flush_stall", stall_o, 0);
      tick();
      valid_i = 1'b0; flush_i = 1'b0;
      held = reg_wdata_o;
      chk("idle_flush_valid", valid_o, 0);
      chk("idle_flush_held", held, 32'd5);
      tick();

      // reset in the middle of BUSY
      aluOp_i = 8'd16; op1_i = 32'd7; op2_i = 32'd9; reg_waddr_i = 5'd9; valid_i = 1'b1;
      tick();
      repeat (5) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; valid_i = 1'b0;
      #1;
      chk("busy_rst_valid", valid_o, 0);
      chk("busy_rst_we", reg_we_o, 0);
      chk("busy_rst_waddr", reg_waddr_o, 0);
      chk("busy_rst_wdata", reg_wdata_o, 0);
      chk("busy_rst_stall", stall_o, 0);
      tick();
      run_op(8'd16, 32'd7, 32'd9, 1'b1, 5'd9, got);
      chk("mul_after_rst", got, 32'd63);
      tick();

      // randomized ops against the model
      for (int n = 0; n < 40; n++) begin
         run_op(ops[$urandom_range(0, 17)], rnd_opnd(), rnd_opnd(),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), got);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
